pulse_event_detect: RTL and testbench
=====================================

Name: pulse_event_detect

Overview:
- Downstream neighbour of the baseline drift tracker.
- Subtracts the tracked drift from each raw sample to form a saturated residual.
- Runs a hysteresis event FSM on that residual and reports one summary per qualified event: peak, peak position, width and area.
- Feeds the event/readout logic; the residual stream is also exported for monitoring.

Parameters:
- W, 24, sample / drift / residual / threshold width (signed).
- CW, 16, event width and holdoff counter width.
- AW, 40, area accumulator width (signed; W+CW).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- din  in  W  raw signed sample.
- din_valid  in  1  sample strobe.
- drift_in  in  W  signed baseline from the drift tracker, same cycle as din (pre-update value).
- on_th  in  W  signed event-entry threshold.
- off_th  in  W  signed event-exit threshold (normally <= on_th).
- min_width  in  8  minimum qualifying width in samples; 0 is treated as 1.
- holdoff  in  CW  samples ignored after a reported event.
- res_out  out  W  saturated residual.
- res_valid  out  1  residual strobe.
- evt_valid  out  1  one-cycle event report pulse.
- evt_peak  out  W  maximum residual in the event.
- evt_peak_pos  out  CW  0-based sample index of the peak within the event.
- evt_width  out  CW  samples in the event.
- evt_area  out  AW  saturated sum of event residuals.
- evt_sat  out  1  width or area saturated during the reported event.
- busy  out  1  FSM not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge): every output, register and the FSM clear to 0 / IDLE. Reset during an event discards it; no evt_valid is produced.
- Residual path:
  - Compute din - drift_in in W+1 bits, then clip to [-2^(W-1), 2^(W-1)-1].
  - res_out and res_valid are registered one cycle after din_valid.
  - res_out holds its value between strobes; res_valid is high only for the strobe cycle.
- Event FSM: advances only on res_valid cycles and holds state across din_valid gaps. Thresholds are sampled live on each res_valid. States:
  - IDLE: if res_out >= on_th, go to ACTIVE and load width=1, peak=res, pos=0, area=res, sat=0.
  - ACTIVE, res_out < off_th: the event ends and the terminating sample is excluded.
    - If width >= max(min_width,1): latch the evt_* outputs, pulse evt_valid the next cycle, then go to HOLDOFF with cnt=holdoff, or to IDLE if holdoff=0.
    - Otherwise go to IDLE silently.
  - ACTIVE, otherwise: pos_candidate = width (pre-increment); width += 1, saturating at 2^CW-1; area += res, saturating to AW signed range; either saturation sets sat. If res > peak (strict), update peak and pos, so the first maximum wins.
  - HOLDOFF: ignore the sample and decrement cnt. When cnt reaches 0, go to IDLE; the next sample is evaluated in IDLE.
- Timing: evt_valid is high in the cycle after the res_valid cycle carrying the terminating sample, i.e. 2 cycles after its din_valid.
- evt_* outputs hold their last reported values until the next report. They are unchanged by discarded events.
- off_th > on_th is legal; the event then ends on the first sample below off_th.
- busy = (state != IDLE).

Decomposition:
- Shared package/header holds:
  - state encoding localparams: IDLE=2'd0, ACTIVE=2'd1, HOLDOFF=2'd2;
  - saturation limit constants derived from W and AW.
- One natural sub-module, sat_sub: a combinational W-bit signed saturating subtractor used for the residual. The FSM and accumulators stay in the top.

Test Plan:
- Residual path:
  - din=1000, drift_in=400 -> res_out=600, res_valid high 1 cycle after din_valid.
  - din=24'h7FFFFF, drift_in=-10 -> res_out=24'h7FFFFF (positive clip).
  - din=24'h800000, drift_in=5 -> res_out=24'h800000 (negative clip).
- Qualified event: on_th=100, off_th=50, min_width=3, holdoff=0; residuals 0,120,300,200,80,40 -> single evt_valid 1 cycle after the 40 strobe; width=4, peak=300, pos=1, area=700, sat=0.
- Glitch rejection: same thresholds; residuals 150,30 -> no evt_valid, busy drops after the 30 sample, evt_* unchanged.
- Holdoff: holdoff=4; after a reported event, residuals 500,500,500,500 are ignored (busy=1), and the 5th sample 500 starts a new event.
- Stall and tie: during ACTIVE, din_valid low for 10 cycles, then residuals 300,300,10 -> width counts only valid samples; peak pos is the first 300.
- Reset mid-event: rst_n low for 1 cycle while ACTIVE -> busy=0, all outputs 0, no evt_valid ever emitted for that event.

Source files
------------

// File: rtl/pulse_event_detect_pkg.sv
// Shared types and default sizing for the pulse event detector.
// Limit constants describe the saturation bounds at the default widths.
package pulse_event_detect_pkg;

  localparam int PED_W  = 24;
  localparam int PED_CW = 16;
  localparam int PED_AW = 40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  localparam logic signed [PED_W-1:0]  RES_MAX   = {1'b0, {(PED_W-1){1'b1}}};
  localparam logic signed [PED_W-1:0]  RES_MIN   = {1'b1, {(PED_W-1){1'b0}}};
  localparam logic signed [PED_AW-1:0] AREA_MAX  = {1'b0, {(PED_AW-1){1'b1}}};
  localparam logic signed [PED_AW-1:0] AREA_MIN  = {1'b1, {(PED_AW-1){1'b0}}};
  localparam logic [PED_CW-1:0]        WIDTH_MAX = {PED_CW{1'b1}};

endpackage

// File: rtl/pulse_event_detect_sat_sub.sv
// Combinational signed a - b, clipped to the W-bit signed range.
module sat_sub #(
  parameter int W = 24
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] y
);

  logic signed [W:0] diff;

  assign diff = {a[W-1], a} - {b[W-1], b};

  // The two top bits disagree exactly when the true difference left the W-bit range.
  assign y = (diff[W] != diff[W-1]) ? (diff[W] ? {1'b1, {(W-1){1'b0}}}
                                               : {1'b0, {(W-1){1'b1}}})
                                    : diff[W-1:0];

endmodule

// File: rtl/pulse_event_detect.sv
// Baseline-subtracted residual stream with a hysteresis event detector
// that reports peak, peak position, width and area of each qualified event.
module pulse_event_detect
  import pulse_event_detect_pkg::*;
#(
  parameter int W  = PED_W,
  parameter int CW = PED_CW,
  parameter int AW = PED_AW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic signed [W-1:0]  din,
  input  logic                 din_valid,
  input  logic signed [W-1:0]  drift_in,
  input  logic signed [W-1:0]  on_th,
  input  logic signed [W-1:0]  off_th,
  input  logic [7:0]           min_width,
  input  logic [CW-1:0]        holdoff,
  output logic signed [W-1:0]  res_out,
  output logic                 res_valid,
  output logic                 evt_valid,
  output logic signed [W-1:0]  evt_peak,
  output logic [CW-1:0]        evt_peak_pos,
  output logic [CW-1:0]        evt_width,
  output logic signed [AW-1:0] evt_area,
  output logic                 evt_sat,
  output logic                 busy
);

  localparam logic signed [AW-1:0] AREA_HI = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AREA_LO = {1'b1, {(AW-1){1'b0}}};
  localparam logic [CW-1:0]        WID_HI  = {CW{1'b1}};

  logic signed [W-1:0] res_sat;

  sat_sub #(.W(W)) u_sat_sub (
    .a (din),
    .b (drift_in),
    .y (res_sat)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_out   <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= din_valid;
      if (din_valid) res_out <= res_sat;
    end
  end

  state_t              state, state_nx;
  logic [CW-1:0]       width_q, width_nx, pos_q, pos_nx, cnt_q, cnt_nx;
  logic signed [W-1:0] peak_q, peak_nx;
  logic signed [AW-1:0] area_q, area_nx;
  logic                sat_q, sat_nx, evt_load;
  logic signed [AW:0]  area_sum;
  logic [CW-1:0]       min_eff;

  assign min_eff  = (min_width == 8'd0) ? CW'(1) : CW'(min_width);
  assign area_sum = {area_q[AW-1], area_q} + {{(AW+1-W){res_out[W-1]}}, res_out};
  assign busy     = (state != IDLE);

  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    state_nx = state;
    width_nx = width_q;
    pos_nx   = pos_q;
    cnt_nx   = cnt_q;
    peak_nx  = peak_q;
    area_nx  = area_q;
    sat_nx   = sat_q;
    evt_load = 1'b0;
    if (res_valid) begin
      unique case (state)
        IDLE: begin
          if (res_out >= on_th) begin
            state_nx = ACTIVE;
            width_nx = CW'(1);
            pos_nx   = '0;
            peak_nx  = res_out;
            area_nx  = {{(AW-W){res_out[W-1]}}, res_out};
            sat_nx   = 1'b0;
          end
        end
        ACTIVE: begin
          if (res_out < off_th) begin
            if (width_q >= min_eff) begin
              evt_load = 1'b1;
              cnt_nx   = holdoff;
              state_nx = (holdoff == '0) ? IDLE : HOLDOFF;
            end else begin
              state_nx = IDLE;
            end
          end else begin
            if (width_q == WID_HI) sat_nx = 1'b1;
            else                   width_nx = width_q + CW'(1);
            if (area_sum[AW] != area_sum[AW-1]) begin
              area_nx = area_sum[AW] ? AREA_LO : AREA_HI;
              sat_nx  = 1'b1;
            end else begin
              area_nx = area_sum[AW-1:0];
            end
            // Strict compare keeps the position of the first maximum.
            if (res_out > peak_q) begin
              peak_nx = res_out;
              pos_nx  = width_q;
            end
          end
        end
        HOLDOFF: begin
          cnt_nx = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
          if (cnt_q <= CW'(1)) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      width_q      <= '0;
      pos_q        <= '0;
      cnt_q        <= '0;
      peak_q       <= '0;
      area_q       <= '0;
      sat_q        <= 1'b0;
      evt_valid    <= 1'b0;
      evt_peak     <= '0;
      evt_peak_pos <= '0;
      evt_width    <= '0;
      evt_area     <= '0;
      evt_sat      <= 1'b0;
    end else begin
      state     <= state_nx;
      width_q   <= width_nx;
      pos_q     <= pos_nx;
      cnt_q     <= cnt_nx;
      peak_q    <= peak_nx;
      area_q    <= area_nx;
      sat_q     <= sat_nx;
      evt_valid <= evt_load;
      if (evt_load) begin
        evt_peak     <= peak_q;
        evt_peak_pos <= pos_q;
        evt_width    <= width_q;
        evt_area     <= area_q;
        evt_sat      <= sat_q;
      end
    end
  end

endmodule

// File: tb/tb_pulse_event_detect.sv
// Directed scoreboard bench: expected residuals and event reports are queued
// when samples are driven and compared when the DUT strobes them.
module tb_pulse_event_detect;
  import pulse_event_detect_pkg::*;

  localparam int W  = PED_W;
  localparam int CW = PED_CW;
  localparam int AW = PED_AW;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic signed [W-1:0]  din, drift_in, on_th, off_th;
  logic                 din_valid;
  logic [7:0]           min_width;
  logic [CW-1:0]        holdoff;
  logic signed [W-1:0]  res_out;
  logic                 res_valid, evt_valid, evt_sat, busy;
  logic signed [W-1:0]  evt_peak;
  logic [CW-1:0]        evt_peak_pos, evt_width;
  logic signed [AW-1:0] evt_area;

  typedef struct {
    longint val;
    longint cyc;
  } exp_res_t;

  typedef struct {
    longint peak;
    longint pos;
    longint width;
    longint area;
    longint sat;
    longint cyc;
  } exp_evt_t;

  exp_res_t res_q[$];
  exp_evt_t evt_q[$];
  int       errors = 0;
  int       checks = 0;
  longint   cyc = 0;

  pulse_event_detect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .din          (din),
    .din_valid    (din_valid),
    .drift_in     (drift_in),
    .on_th        (on_th),
    .off_th       (off_th),
    .min_width    (min_width),
    .holdoff      (holdoff),
    .res_out      (res_out),
    .res_valid    (res_valid),
    .evt_valid    (evt_valid),
    .evt_peak     (evt_peak),
    .evt_peak_pos (evt_peak_pos),
    .evt_width    (evt_width),
    .evt_area     (evt_area),
    .evt_sat      (evt_sat),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint clip(input longint d);
    if (d > longint'(RES_MAX)) return longint'(RES_MAX);
    if (d < longint'(RES_MIN)) return longint'(RES_MIN);
    return d;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input longint r_din, input longint r_drift);
    exp_res_t e;
    din       = r_din[W-1:0];
    drift_in  = r_drift[W-1:0];
    din_valid = 1'b1;
    e.val = clip(longint'(din) - longint'(drift_in));
    e.cyc = cyc + 1;
    res_q.push_back(e);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // Call immediately before sending the terminating sample.
  task automatic expect_evt(input longint peak, input longint pos, input longint width,
                            input longint area, input longint sat);
    exp_evt_t e;
    e.peak = peak; e.pos = pos; e.width = width; e.area = area; e.sat = sat;
    e.cyc  = cyc + 2;
    evt_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      if (res_q.size() == 0) begin
        check("res_valid_unexpected", 64'(res_valid), 64'd0);
      end else begin
        exp_res_t e;
        e = res_q.pop_front();
        check("res_out", 64'(res_out), e.val);
        check("res_cycle", cyc, e.cyc);
      end
    end
    if (evt_valid === 1'b1) begin
      if (evt_q.size() == 0) begin
        check("evt_valid_unexpected", 64'(evt_valid), 64'd0);
      end else begin
        exp_evt_t e;
        e = evt_q.pop_front();
        check("evt_peak", 64'(evt_peak), e.peak);
        check("evt_peak_pos", 64'(evt_peak_pos), e.pos);
        check("evt_width", 64'(evt_width), e.width);
        check("evt_area", 64'(evt_area), e.area);
        check("evt_sat", 64'(evt_sat), e.sat);
        check("evt_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic check_all_zero(input string phase);
    check({phase, "_busy"}, 64'(busy), 64'd0);
    check({phase, "_res_out"}, 64'(res_out), 64'd0);
    check({phase, "_res_valid"}, 64'(res_valid), 64'd0);
    check({phase, "_evt_valid"}, 64'(evt_valid), 64'd0);
    check({phase, "_evt_peak"}, 64'(evt_peak), 64'd0);
    check({phase, "_evt_pos"}, 64'(evt_peak_pos), 64'd0);
    check({phase, "_evt_width"}, 64'(evt_width), 64'd0);
    check({phase, "_evt_area"}, 64'(evt_area), 64'd0);
    check({phase, "_evt_sat"}, 64'(evt_sat), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; din = '0; drift_in = '0; din_valid = 1'b0;
    on_th = 24'sd100; off_th = 24'sd50; min_width = 8'd3; holdoff = '0;
    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // Residual path, including both clip limits; the 600/max run is too short to report.
    send(1000, 400);
    send(8388607, -10);
    send(-8388608, 5);
    idle(2);
    check("short_run_busy", 64'(busy), 64'd0);

    // Qualified event.
    send(0, 0); send(120, 0); send(300, 0); send(200, 0); send(80, 0);
    expect_evt(300, 1, 4, 700, 0);
    send(40, 0);
    idle(3);
    check("after_evt_busy", 64'(busy), 64'd0);

    // Glitch rejection leaves the last report untouched.
    send(150, 0);
    idle(1);
    check("glitch_busy_high", 64'(busy), 64'd1);
    send(30, 0);
    idle(2);
    check("glitch_busy_low", 64'(busy), 64'd0);
    check("glitch_keep_peak", 64'(evt_peak), 64'd300);
    check("glitch_keep_width", 64'(evt_width), 64'd4);
    check("glitch_keep_area", 64'(evt_area), 64'd700);
    check("glitch_keep_pos", 64'(evt_peak_pos), 64'd1);

    // Holdoff of 4 samples after a report.
    holdoff = 16'd4;
    send(200, 0); send(200, 0); send(200, 0);
    expect_evt(200, 0, 3, 600, 0);
    send(10, 0);
    send(500, 0); send(500, 0); send(500, 0);
    idle(1);
    check("holdoff_busy", 64'(busy), 64'd1);
    send(500, 0);
    idle(1);
    check("holdoff_done_busy", 64'(busy), 64'd0);
    holdoff = '0;
    send(500, 0); send(500, 0); send(500, 0);
    expect_evt(500, 0, 3, 1500, 0);
    send(10, 0);
    idle(3);

    // Stall inside an event, then a tie for the peak.
    send(200, 0);
    idle(10);
    check("stall_busy", 64'(busy), 64'd1);
    send(300, 0); send(300, 0);
    expect_evt(300, 1, 3, 800, 0);
    send(10, 0);
    idle(3);

    // min_width of 0 behaves as 1.
    min_width = 8'd0;
    send(150, 0);
    expect_evt(150, 0, 1, 150, 0);
    send(30, 0);
    idle(3);

    // Exit threshold above entry threshold.
    min_width = 8'd1; off_th = 24'sd200;
    send(150, 0);
    expect_evt(150, 0, 1, 150, 0);
    send(180, 0);
    idle(3);
    off_th = 24'sd50; min_width = 8'd3;

    // Reset in the middle of an event discards it.
    send(500, 0);
    idle(2);
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    idle(1);
    check_all_zero("mid_reset");
    rst_n = 1'b1;
    send(10, 0);
    idle(5);
    check("post_reset_busy", 64'(busy), 64'd0);

    check("res_q_left", 64'(res_q.size()), 64'd0);
    check("evt_q_left", 64'(evt_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
